// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin arbiter sharing one AXI-style write channel between NUM_REQ requesters
// Optional per-requester grant counters: define AXI_WR_ARB_STATS_EN.
module axi_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_valid,
  input  logic                      write_ready,
  input  logic                      fifo_full,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
`ifdef AXI_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_count,
  input  logic                      stats_clr
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [GW-1:0]       gid_q, gid_d;
  logic [GW-1:0]       last_q, last_d;

  logic                stage_free;
  logic                grant_permit;
  logic                win_found;
  logic [GW-1:0]       win_id;
  logic [GW-1:0]       cand;
  logic                accept;

  // The output stage can take a new beat in the same cycle the current one retires.
  assign stage_free   = (state_q == IDLE) || (valid_q && write_ready);
  assign grant_permit = rst_n && !fifo_full && stage_free;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign accept    = grant_permit && win_found;
  assign req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    last_d  = last_q;
    if (accept) begin
      state_d = DRIVE;
      valid_d = 1'b1;
      addr_d  = req_addr[win_id*ADDR_W +: ADDR_W];
      data_d  = req_data[win_id*DATA_W +: DATA_W];
      gid_d   = win_id;
      last_d  = win_id;
    end else if (state_q == DRIVE && valid_q && write_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end

  assign write_valid = valid_q;
  assign write_addr  = addr_q;
  assign write_data  = data_q;
  assign grant_id    = gid_q;
  assign busy        = (state_q == DRIVE);

`ifdef AXI_WR_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (accept && cnt_q[win_id] != 16'hFFFF) begin
      cnt_q[win_id] <= cnt_q[win_id] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_pack
    assign grant_count[gi*16 +: 16] = cnt_q[gi];
  end
`endif

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write channel of the AXI-style FIFO slave between NUM_REQ requesters.
- Sits between testbench or system masters and the slave's write port.
- Accepts one request per grant into a registered output stage and drives write_addr/write_data/write_valid until the slave returns write_ready.
- Gates new grants on fifo_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  per-requester data, same packing.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- write_addr  out  ADDR_W  to slave.
- write_data  out  DATA_W  to slave.
- write_valid  out  1  to slave.
- write_ready  in  1  from slave.
- fifo_full  in  1  slave status.
- grant_id  out  $clog2(NUM_REQ)  index of the requester whose beat is currently on the slave port.
- busy  out  1  high while in DRIVE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; write_valid=0; write_addr=0; write_data=0; grant_id=0; busy=0; last_grant=NUM_REQ-1 (so requester 0 wins first).
- req_ready is combinational and never high while rst_n=0.
- Eligibility: a grant is permitted only when fifo_full=0 and the output stage is free. The output stage is free when state=IDLE, or when state=DRIVE with write_valid&&write_ready in the current cycle.
- Arbitration: when the grant is permitted, scan req_valid starting at (last_grant+1) mod NUM_REQ, wrapping. The first set bit g wins.
  - req_ready[g]=1 that cycle; all other req_ready bits are 0.
  - The handshake req_valid[g]&&req_ready[g] is the accept.
- Accept effects on the next edge:
  - write_addr/write_data are loaded from slot g.
  - grant_id=g, last_grant=g, write_valid=1, state=DRIVE.
- Latency: accept in cycle N means write_valid=1 with the accepted beat from cycle N+1.
- DRIVE: write_addr, write_data and grant_id are held stable while write_valid=1 and write_ready=0. AXI rule: no retraction, no data change.
- On write_valid&&write_ready:
  - If a new accept occurs in the same cycle, stay in DRIVE with the new beat (back-to-back, zero bubble).
  - Otherwise write_valid=0 and state=IDLE on the next edge.
- fifo_full=1: no new accepts and all req_ready=0. A beat already in DRIVE stays presented and completes normally on write_ready.
- Simultaneous requests: strict round-robin. The requester just served has lowest priority on the next grant.
- req_valid deasserting without an accept: no effect, nothing latched.
- Single active requester: it is granted back-to-back at full rate.
- Reset mid-DRIVE: the beat is dropped, write_valid falls immediately (asynchronous), and nothing is replayed after reset.
- busy = (state==DRIVE).

Optional Feature:
- Macro: AXI_WR_ARB_STATS_EN.
- With the macro defined:
  - Adds output grant_count, width NUM_REQ*16: one 16-bit saturating counter per requester, incremented on each accept, saturating at 16'hFFFF, reset to 0.
  - Adds input stats_clr, width 1: synchronous clear of all counters. A clear and an increment in the same cycle result in 0.
- Without the macro: neither port exists, and the remaining behaviour is identical.

Test Plan:
- Reset → write_valid=0, req_ready=0, grant_id=0, busy=0. Assert rst_n=0 during DRIVE → write_valid drops before the next clk edge.
- All 4 requesters valid continuously, write_ready=1 → grant order 0,1,2,3,0,1; one beat per cycle; write_addr equals each requester's address, e.g. 32'h1000_0000+i.
- Requester 2 only, write_addr=32'hA5A5_0002, write_data=32'hDEAD_BEEF, write_ready held 0 for 5 cycles → outputs stable for 5 cycles; no req_ready to any other requester; beat completes on the cycle write_ready rises.
- fifo_full=1 with req_valid=4'b1111 for 10 cycles → req_ready=0 throughout, no new beat accepted. Drop fifo_full → requester 0 granted on that cycle.
- Requester 1 served, then req_valid=4'b0011 → requester 0 wins next, then requester 1 (wrap-around fairness).
- AXI_WR_ARB_STATS_EN: 70000 accepts on requester 3 → grant_count[3]=16'hFFFF. Pulse stats_clr → all counters 0.
